// File: rtl/dma_port_emu.sv
// DMA port emulator: paced read ports walking sliding windows and paced write
// ports capturing engine results, all sharing one preloadable word memory.
module dma_port_emu #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int N_RD   = 4,
  parameter int N_WR   = 2,
  parameter int GAP    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [DATA_W-1:0]      load_data,
  input  logic [N_RD-1:0]        reads_en,
  input  logic [N_RD-1:0]        rd_restart,
  input  logic [N_RD*ADDR_W-1:0] rd_base,
  input  logic [N_RD*ADDR_W-1:0] rd_len,
  input  logic [N_RD*ADDR_W-1:0] rd_slide,
  input  logic [N_RD*16-1:0]     rd_nwin,
  output logic [N_RD-1:0]        ob_we,
  output logic [N_RD*DATA_W-1:0] ob_data,
  output logic [N_RD-1:0]        rd_done,
  input  logic [N_WR-1:0]        writes_en,
  input  logic [N_WR*ADDR_W-1:0] wr_base,
  input  logic [N_WR-1:0]        wr_restart,
  input  logic [N_WR*DATA_W-1:0] ib_data,
  input  logic [N_WR-1:0]        ib_valid,
  output logic [N_WR-1:0]        ib_re,
  output logic [N_WR*16-1:0]     wr_count
);
  localparam int PH_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [PH_W-1:0]   PH_MAX = PH_W'(GAP);
  localparam logic [PH_W-1:0]   PH_ONE = PH_W'(1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic [PH_W-1:0]   rph_q [N_RD];
  logic [PH_W-1:0]   rph_d [N_RD];
  logic [ADDR_W-1:0] win_q [N_RD];
  logic [ADDR_W-1:0] win_d [N_RD];
  logic [ADDR_W-1:0] pos_q [N_RD];
  logic [ADDR_W-1:0] pos_d [N_RD];
  logic [15:0]       nw_q  [N_RD];
  logic [15:0]       nw_d  [N_RD];
  logic [DATA_W-1:0] obd_q [N_RD];
  logic [DATA_W-1:0] obd_d [N_RD];
  logic [N_RD-1:0]   done_q, done_d, we_q, we_d, rbeat;

  logic [PH_W-1:0]   wph_q [N_WR];
  logic [PH_W-1:0]   wph_d [N_WR];
  logic [ADDR_W-1:0] ptr_q [N_WR];
  logic [ADDR_W-1:0] ptr_d [N_WR];
  logic [15:0]       cnt_q [N_WR];
  logic [15:0]       cnt_d [N_WR];
  logic [N_WR-1:0]   re_q, re_d, wcap;

  // Read ports: restart overrides the beat; a finished port parks at phase 0.
  always_comb begin
    for (int i = 0; i < N_RD; i++) begin
      rph_d[i]  = rph_q[i];
      win_d[i]  = win_q[i];
      pos_d[i]  = pos_q[i];
      nw_d[i]   = nw_q[i];
      obd_d[i]  = obd_q[i];
      done_d[i] = done_q[i];
      we_d[i]   = 1'b0;
      rbeat[i]  = 1'b0;
      if (rd_restart[i]) begin
        rph_d[i]  = '0;
        win_d[i]  = rd_base[i*ADDR_W +: ADDR_W];
        pos_d[i]  = '0;
        nw_d[i]   = '0;
        done_d[i] = 1'b0;
      end else if (!reads_en[i] || done_q[i]) begin
        rph_d[i] = '0;
      end else if (rph_q[i] == PH_MAX) begin
        rph_d[i] = '0;
        rbeat[i] = 1'b1;
      end else begin
        rph_d[i] = rph_q[i] + PH_ONE;
      end
      if (rbeat[i]) begin
        we_d[i]  = 1'b1;
        obd_d[i] = mem_q[win_q[i] + pos_q[i]];
        if (pos_q[i] == rd_len[i*ADDR_W +: ADDR_W] - A_ONE || rd_len[i*ADDR_W +: ADDR_W] == '0) begin
          pos_d[i] = '0;
          win_d[i] = win_q[i] + rd_slide[i*ADDR_W +: ADDR_W];
          nw_d[i]  = nw_q[i] + 16'd1;
          if (rd_nwin[i*16 +: 16] != '0 && nw_q[i] + 16'd1 == rd_nwin[i*16 +: 16])
            done_d[i] = 1'b1;
        end else begin
          pos_d[i] = pos_q[i] + A_ONE;
        end
      end
    end
  end

  // Write ports: capture happens on the edge after ib_re was raised.
  always_comb begin
    for (int j = 0; j < N_WR; j++) begin
      wph_d[j] = wph_q[j];
      ptr_d[j] = ptr_q[j];
      cnt_d[j] = cnt_q[j];
      re_d[j]  = 1'b0;
      wcap[j]  = re_q[j] & ib_valid[j] & ~wr_restart[j] & ~rst;
      if (wr_restart[j]) begin
        wph_d[j] = '0;
        ptr_d[j] = wr_base[j*ADDR_W +: ADDR_W];
        cnt_d[j] = '0;
      end else begin
        if (wcap[j]) begin
          ptr_d[j] = ptr_q[j] + A_ONE;
          cnt_d[j] = cnt_q[j] + 16'd1;
        end
        if (!writes_en[j]) begin
          wph_d[j] = '0;
        end else if (wph_q[j] == PH_MAX) begin
          wph_d[j] = '0;
          re_d[j]  = 1'b1;
        end else begin
          wph_d[j] = wph_q[j] + PH_ONE;
        end
      end
    end
  end

  // Later assignments win, so the loop runs from lowest to highest priority.
  always_ff @(posedge clk) begin
    for (int j = N_WR - 1; j >= 0; j--)
      if (wcap[j]) mem_q[ptr_q[j]] <= ib_data[j*DATA_W +: DATA_W];
    if (load_en) mem_q[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_RD; i++) begin
        rph_q[i] <= '0;
        win_q[i] <= '0;
        pos_q[i] <= '0;
        nw_q[i]  <= '0;
        obd_q[i] <= '0;
      end
      for (int j = 0; j < N_WR; j++) begin
        wph_q[j] <= '0;
        ptr_q[j] <= '0;
        cnt_q[j] <= '0;
      end
      done_q <= '0;
      we_q   <= '0;
      re_q   <= '0;
    end else begin
      for (int i = 0; i < N_RD; i++) begin
        rph_q[i] <= rph_d[i];
        win_q[i] <= win_d[i];
        pos_q[i] <= pos_d[i];
        nw_q[i]  <= nw_d[i];
        obd_q[i] <= obd_d[i];
      end
      for (int j = 0; j < N_WR; j++) begin
        wph_q[j] <= wph_d[j];
        ptr_q[j] <= ptr_d[j];
        cnt_q[j] <= cnt_d[j];
      end
      done_q <= done_d;
      we_q   <= we_d;
      re_q   <= re_d;
    end
  end

  assign ob_we   = we_q;
  assign rd_done = done_q;
  assign ib_re   = re_q;

  for (genvar g = 0; g < N_RD; g++) begin : g_rd_out
    assign ob_data[g*DATA_W +: DATA_W] = obd_q[g];
  end
  for (genvar g = 0; g < N_WR; g++) begin : g_wr_out
    assign wr_count[g*16 +: 16] = cnt_q[g];
  end
endmodule

// File: tb/tb_dma_port_emu.sv
// Bench for dma_port_emu: window streams, pause, write capture, collision, reset,
// checked against a shadow memory and a window-address formula.
module tb_dma_port_emu;
  localparam int DW = 16, AW = 10, NR = 4, NW = 2, GAP = 2;
  localparam int DEPTH = 1024, PER = GAP + 1;

  logic clk = 1'b0;
  logic rst, load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic [NR-1:0] reads_en, rd_restart, ob_we, rd_done;
  logic [NR*AW-1:0] rd_base, rd_len, rd_slide;
  logic [NR*16-1:0] rd_nwin;
  logic [NR*DW-1:0] ob_data;
  logic [NW-1:0] writes_en, wr_restart, ib_valid, ib_re;
  logic [NW*AW-1:0] wr_base;
  logic [NW*DW-1:0] ib_data;
  logic [NW*16-1:0] wr_count;

  dma_port_emu #(.DATA_W(DW), .ADDR_W(AW), .N_RD(NR), .N_WR(NW), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .reads_en(reads_en), .rd_restart(rd_restart), .rd_base(rd_base), .rd_len(rd_len),
    .rd_slide(rd_slide), .rd_nwin(rd_nwin), .ob_we(ob_we), .ob_data(ob_data),
    .rd_done(rd_done), .writes_en(writes_en), .wr_base(wr_base), .wr_restart(wr_restart),
    .ib_data(ib_data), .ib_valid(ib_valid), .ib_re(ib_re), .wr_count(wr_count));

  always #5 clk = ~clk;

  logic [DW-1:0] ref_mem [DEPTH];
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    load_en = 1'b1; load_addr = AW'(a); load_data = d;
    tick();
    load_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic rd_setup(input int p, input int base, input int len, input int slide, input int nwin);
    rd_base[p*AW +: AW]  = AW'(base);
    rd_len[p*AW +: AW]   = AW'(len);
    rd_slide[p*AW +: AW] = AW'(slide);
    rd_nwin[p*16 +: 16]  = 16'(nwin);
    reads_en[p] = 1'b0; rd_restart[p] = 1'b1;
    tick();
    rd_restart[p] = 1'b0;
  endtask

  task automatic wait_ob(input int p, output int c);
    c = 0;
    do begin tick(); c++; end while (!ob_we[p] && c < 20);
  endtask

  task automatic wait_re(input int j, output int c);
    c = 0;
    do begin tick(); c++; end while (!ib_re[j] && c < 20);
  endtask

  // Beat k of a stream reads base + (k/len)*slide + (k%len), modulo the depth.
  task automatic expect_stream(input int p, input int base, input int len, input int slide,
                               input int k0, input int n, input string tag);
    int c, a;
    for (int k = k0; k < k0 + n; k++) begin
      wait_ob(p, c);
      a = (base + (k / len) * slide + (k % len)) % DEPTH;
      chk({tag, "_gap"}, 64'(c), 64'(PER));
      chk({tag, "_data"}, 64'(ob_data[p*DW +: DW]), 64'(ref_mem[a]));
    end
  endtask

  task automatic expect_quiet(input int p, input int n, input string tag);
    int pulses = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (ob_we[p]) pulses++;
    end
    chk(tag, 64'(pulses), 64'd0);
  endtask

  task automatic wr_run(input int j, input int base, input int n, input logic [DW-1:0] dbase,
                        input int skip, input string tag);
    int c, ptr;
    wr_base[j*AW +: AW] = AW'(base);
    writes_en[j] = 1'b0; wr_restart[j] = 1'b1;
    tick();
    wr_restart[j] = 1'b0; writes_en[j] = 1'b1; ptr = base;
    for (int b = 0; b < n; b++) begin
      wait_re(j, c);
      chk({tag, "_gap"}, 64'(c), 64'(PER));
      ib_data[j*DW +: DW] = dbase + DW'(b);
      ib_valid[j] = (b != skip);
      if (b == n - 1) writes_en[j] = 1'b0;
      if (b != skip) begin
        ref_mem[ptr % DEPTH] = dbase + DW'(b);
        ptr++;
      end
    end
    tick();
    ib_valid[j] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int c, base, len, slide, nwin;
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    reads_en = '0; rd_restart = '0; rd_base = '0; rd_len = '0; rd_slide = '0; rd_nwin = '0;
    writes_en = '0; wr_base = '0; wr_restart = '0; ib_data = '0; ib_valid = '0;
    repeat (3) tick();
    chk("rst_ob_we", 64'(ob_we), 64'd0);
    chk("rst_ob_data", ob_data, 64'd0);
    chk("rst_rd_done", 64'(rd_done), 64'd0);
    chk("rst_ib_re", 64'(ib_re), 64'd0);
    chk("rst_wr_count", 64'(wr_count), 64'd0);
    rst = 1'b0;

    for (int a = 0; a < DEPTH; a++)
      load(a, (a < 75) ? DW'(a + 1) : DW'($urandom));

    // Sliding window, two windows, then the port stops.
    rd_setup(0, 0, 46, 1, 2);
    reads_en[0] = 1'b1;
    expect_stream(0, 0, 46, 1, 0, 92, "win");
    chk("win_done", 64'(rd_done[0]), 64'd1);
    expect_quiet(0, 12, "win_quiet");
    reads_en[0] = 1'b0;

    // Circular weights with a mid-window pause.
    rd_setup(1, 100, 27, 0, 0);
    reads_en[1] = 1'b1;
    expect_stream(1, 100, 27, 0, 0, 30, "circ");
    reads_en[1] = 1'b0;
    expect_quiet(1, 5, "pause_quiet");
    reads_en[1] = 1'b1;
    expect_stream(1, 100, 27, 0, 30, 10, "resume");
    chk("circ_not_done", 64'(rd_done[1]), 64'd0);
    reads_en[1] = 1'b0;

    // Random window geometry.
    for (int r = 0; r < 3; r++) begin
      base = $urandom_range(0, DEPTH - 1); len = $urandom_range(1, 12);
      slide = $urandom_range(0, DEPTH - 1); nwin = $urandom_range(1, 3);
      rd_setup(2, base, len, slide, nwin);
      reads_en[2] = 1'b1;
      expect_stream(2, base, len, slide, 0, len * nwin, "rnd");
      chk("rnd_done", 64'(rd_done[2]), 64'd1);
      expect_quiet(2, 6, "rnd_quiet");
      reads_en[2] = 1'b0;
    end

    // Address wrap at the top of memory.
    rd_setup(3, 1022, 4, 0, 1);
    reads_en[3] = 1'b1;
    expect_stream(3, 1022, 4, 0, 0, 4, "wrap");
    chk("wrap_done", 64'(rd_done[3]), 64'd1);
    reads_en[3] = 1'b0;

    // Write capture, all valid.
    wr_run(0, 500, 10, 16'hA000, -1, "wcap");
    chk("wcap_cnt", 64'(wr_count[15:0]), 64'd10);
    rd_setup(3, 500, 10, 0, 1);
    reads_en[3] = 1'b1;
    expect_stream(3, 500, 10, 0, 0, 10, "wcap_rd");
    reads_en[3] = 1'b0;

    // Write capture with one invalid beat.
    wr_run(1, 600, 10, 16'hB000, 3, "wskip");
    chk("wskip_cnt", 64'(wr_count[31:16]), 64'd9);
    rd_setup(3, 600, 10, 0, 1);
    reads_en[3] = 1'b1;
    expect_stream(3, 600, 10, 0, 0, 10, "wskip_rd");
    reads_en[3] = 1'b0;

    // Preload and port-0 capture hit the same word in the same cycle.
    wr_base[0 +: AW] = AW'(700);
    wr_restart[0] = 1'b1;
    tick();
    wr_restart[0] = 1'b0; writes_en[0] = 1'b1;
    wait_re(0, c);
    chk("coll_gap", 64'(c), 64'(PER));
    ib_data[0 +: DW] = 16'h1111; ib_valid[0] = 1'b1; writes_en[0] = 1'b0;
    load_en = 1'b1; load_addr = AW'(700); load_data = 16'h2222;
    tick();
    load_en = 1'b0; ib_valid[0] = 1'b0;
    ref_mem[700] = 16'h2222;
    chk("coll_cnt", 64'(wr_count[15:0]), 64'd1);
    rd_setup(3, 700, 2, 0, 1);
    reads_en[3] = 1'b1;
    expect_stream(3, 700, 2, 0, 0, 2, "coll_rd");
    reads_en[3] = 1'b0;

    // Reset mid-stream, then restart (held with enable) replays the first stream.
    rd_setup(0, 0, 46, 1, 2);
    reads_en[0] = 1'b1; writes_en[1] = 1'b1;
    expect_stream(0, 0, 46, 1, 0, 10, "pre_rst");
    rst = 1'b1;
    tick();
    chk("mid_rst_ob_we", 64'(ob_we), 64'd0);
    chk("mid_rst_ob_data", ob_data, 64'd0);
    chk("mid_rst_rd_done", 64'(rd_done), 64'd0);
    chk("mid_rst_ib_re", 64'(ib_re), 64'd0);
    chk("mid_rst_wr_count", 64'(wr_count), 64'd0);
    rst = 1'b0; writes_en[1] = 1'b0; rd_restart[0] = 1'b1;
    tick();
    chk("restart_no_beat", 64'(ob_we[0]), 64'd0);
    rd_restart[0] = 1'b0;
    expect_stream(0, 0, 46, 1, 0, 92, "replay");
    chk("replay_done", 64'(rd_done[0]), 64'd1);
    reads_en[0] = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
